body_updater: RTL and testbench

BODY_UPDATER -- requirements
Module: body_updater

---
 rtl/snake_pkg.sv | 25 ++
 rtl/next_head_calc.sv | 28 ++
 rtl/body_updater.sv | 112 +++++++++++
 tb/tb_body_updater.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: movement directions, FSM state encoding
// and grid geometry.
package snake_pkg;

   localparam int GRID_BITS = 4;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_CALC  = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;

   // UP/DOWN and LEFT/RIGHT differ only in bit 0.
   function automatic dir_t opposite_dir(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/next_head_calc.sv
// Computes the head cell one step ahead in the given direction, wrapping each
// axis independently modulo the grid size.
module next_head_calc
   import snake_pkg::*;
(
   input  logic [2*GRID_BITS-1:0] i_head,
   input  dir_t                   i_dir,
   output logic [2*GRID_BITS-1:0] o_next_head
);

   logic [GRID_BITS-1:0] w_x;
   logic [GRID_BITS-1:0] w_y;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_x = i_head[2*GRID_BITS-1:GRID_BITS];
      w_y = i_head[GRID_BITS-1:0];
      unique case (i_dir)
         UP:    w_y = i_head[GRID_BITS-1:0] - GRID_BITS'(1);
         DOWN:  w_y = i_head[GRID_BITS-1:0] + GRID_BITS'(1);
         LEFT:  w_x = i_head[2*GRID_BITS-1:GRID_BITS] - GRID_BITS'(1);
         RIGHT: w_x = i_head[2*GRID_BITS-1:GRID_BITS] + GRID_BITS'(1);
         default: ;
      endcase
      o_next_head = {w_x, w_y};
   end

endmodule

// File: rtl/body_updater.sv
// Snake body register file: on each move tick computes the new head, shifts
// every segment down one slot and optionally grows the valid length.
module body_updater
   import snake_pkg::*;
#(
   parameter int                   MAX_LENGTH = 50,
   parameter logic [GRID_BITS-1:0] START_X    = 4'd8,
   parameter logic [GRID_BITS-1:0] START_Y    = 4'd8
)(
   input  logic                        clk,
   input  logic                        nrst,
   input  logic                        restart,
   input  logic                        move_tick,
   input  dir_t                        dir_in,
   input  logic                        grow,
   output logic [MAX_LENGTH-1:0][7:0]  body,
   output logic [7:0]                  curr_length,
   output logic                        full,
   output logic                        update_done
);

   localparam logic [7:0] LEN_INIT  = 8'd2;
   localparam logic [7:0] LEN_MAX   = 8'(MAX_LENGTH - 1);
   localparam logic [7:0] SEG0_INIT = {START_X, START_Y};
   localparam logic [7:0] SEG1_INIT = {START_X - GRID_BITS'(1), START_Y};
   localparam logic [7:0] SEG2_INIT = {START_X - GRID_BITS'(2), START_Y};

   state_t                       r_state;
   dir_t                         r_cur_dir;
   logic                         r_grow_pending;
   logic [7:0]                   r_length;
   logic                         r_update_done;
   logic [7:0]                   r_next_head;
   logic [MAX_LENGTH-1:0][7:0]   r_body;

   logic                         w_clear;
   logic                         w_dir_blocked;
   logic                         w_grow_now;
   logic [7:0]                   w_next_head;

   assign w_clear       = !nrst || restart;
   assign w_dir_blocked = (dir_in == opposite_dir(r_cur_dir)) && (r_length >= 8'd1);
   assign w_grow_now    = r_grow_pending || grow;

   next_head_calc u_next_head_calc (
      .i_head      (r_body[0]),
      .i_dir       (r_cur_dir),
      .o_next_head (w_next_head)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_state        <= ST_IDLE;
         r_cur_dir      <= RIGHT;
         r_grow_pending <= 1'b0;
         r_length       <= LEN_INIT;
         r_update_done  <= 1'b0;
      end else begin
         r_update_done <= (r_state == ST_SHIFT);
         if (!w_dir_blocked)
            r_cur_dir <= dir_in;

         case (r_state)
            ST_IDLE: begin
               if (grow)
                  r_grow_pending <= 1'b1;
               if (move_tick)
                  r_state <= ST_CALC;
            end
            ST_CALC: begin
               if (grow)
                  r_grow_pending <= 1'b1;
               r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (w_grow_now && (r_length != LEN_MAX))
                  r_length <= r_length + 8'd1;
               r_grow_pending <= 1'b0;
               r_state        <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: r_next_head is deliberately unreset; it is always written in CALC before SHIFT reads it.
   always_ff @(posedge clk) begin
      if (r_state == ST_CALC)
         r_next_head <= w_next_head;
   end

   // The body array is reset in full because slots past the tail are visible on the port.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_body    <= '0;
         r_body[0] <= SEG0_INIT;
         r_body[1] <= SEG1_INIT;
         r_body[2] <= SEG2_INIT;
      end else if (r_state == ST_SHIFT) begin
         for (int i = 1; i < MAX_LENGTH; i++)
            r_body[i] <= r_body[i-1];
         r_body[0] <= r_next_head;
      end
   end

   assign body        = r_body;
   assign curr_length = r_length;
   assign full        = (r_length == LEN_MAX);
   assign update_done = r_update_done;

endmodule

// File: tb/tb_body_updater.sv
// Directed self-checking bench for body_updater: a default-size instance and a
// four-slot instance driven by the same stimulus.
module tb_body_updater;
   import snake_pkg::*;

   logic clk = 1'b0;
   logic nrst;
   logic restart;
   logic move_tick;
   dir_t dir_in;
   logic grow;

   logic [49:0][7:0] body;
   logic [7:0]       curr_length;
   logic             full;
   logic             update_done;

   logic [3:0][7:0]  body_s;
   logic [7:0]       len_s;
   logic             full_s;
   logic             done_s;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   body_updater dut (
      .clk         (clk),
      .nrst        (nrst),
      .restart     (restart),
      .move_tick   (move_tick),
      .dir_in      (dir_in),
      .grow        (grow),
      .body        (body),
      .curr_length (curr_length),
      .full        (full),
      .update_done (update_done)
   );

   body_updater #(.MAX_LENGTH(4)) dut_s (
      .clk         (clk),
      .nrst        (nrst),
      .restart     (restart),
      .move_tick   (move_tick),
      .dir_in      (dir_in),
      .grow        (grow),
      .body        (body_s),
      .curr_length (len_s),
      .full        (full_s),
      .update_done (done_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic pulse_grow();
      grow = 1'b1;
      step();
      grow = 1'b0;
      step();
   endtask

   // Issues one move and waits, bounded, for the completion pulse.
   task automatic do_move(input dir_t d);
      bit seen = 1'b0;
      dir_in    = d;
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         step();
         if (update_done) seen = 1'b1;
      end
      check("move_done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nrst      = 1'b0;
      restart   = 1'b0;
      move_tick = 1'b0;
      grow      = 1'b0;
      dir_in    = RIGHT;
      step();
      step();
      nrst = 1'b1;

      check("rst_body0", body[0], 8'h88);
      check("rst_body1", body[1], 8'h78);
      check("rst_body2", body[2], 8'h68);
      check("rst_body3", body[3], 8'h00);
      check("rst_len",   curr_length, 8'd2);
      check("rst_full",  full, 1'b0);
      check("rst_done",  update_done, 1'b0);
      check("rst_full_s", full_s, 1'b0);

      // First move with exact latency; move_tick held into CALC must not queue.
      dir_in    = RIGHT;
      move_tick = 1'b1;
      step();
      check("lat_e1_done", update_done, 1'b0);
      check("lat_e1_body0", body[0], 8'h88);
      step();
      move_tick = 1'b0;
      check("lat_e2_done", update_done, 1'b0);
      check("lat_e2_body0", body[0], 8'h88);
      step();
      check("lat_e3_body0", body[0], 8'h98);
      check("lat_e3_body1", body[1], 8'h88);
      check("lat_e3_body2", body[2], 8'h78);
      check("lat_e3_len",   curr_length, 8'd2);
      check("lat_e3_done",  update_done, 1'b1);
      step();
      check("lat_e4_done", update_done, 1'b0);
      step();
      step();
      step();
      check("no_queue_body0", body[0], 8'h98);
      check("no_queue_done", update_done, 1'b0);

      // Reversal is refused while the snake has a body.
      do_restart();
      check("rev_rst_body0", body[0], 8'h88);
      dir_in = LEFT;
      step();
      do_move(LEFT);
      check("rev_body0", body[0], 8'h98);

      // Wrap-around on both axes, no carry between axes.
      do_restart();
      for (int i = 0; i < 7; i++) do_move(RIGHT);
      check("walk_f8", body[0], 8'hF8);
      for (int i = 0; i < 5; i++) do_move(UP);
      check("walk_f3", body[0], 8'hF3);
      do_move(RIGHT);
      check("wrap_x_03", body[0], 8'h03);
      for (int i = 0; i < 5; i++) do_move(RIGHT);
      for (int i = 0; i < 3; i++) do_move(UP);
      check("walk_50", body[0], 8'h50);
      do_move(UP);
      check("wrap_y_5f", body[0], 8'h5F);
      do_move(DOWN);
      check("rev_down_5e", body[0], 8'h5E);
      do_move(LEFT);
      check("turn_left_4e", body[0], 8'h4E);

      // Grow pulses collapse; grow in the SHIFT cycle applies to that shift.
      do_restart();
      pulse_grow();
      pulse_grow();
      pulse_grow();
      check("grow_before_move", curr_length, 8'd2);
      do_move(RIGHT);
      check("grow_len3", curr_length, 8'd3);
      dir_in    = RIGHT;
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      step();
      grow = 1'b1;
      step();
      grow = 1'b0;
      check("grow_shift_len4", curr_length, 8'd4);
      check("grow_shift_done", update_done, 1'b1);
      check("grow_shift_body0", body[0], 8'hA8);
      check("grow_shift_body4", body[4], 8'h68);

      // Saturation on the four-slot instance.
      do_restart();
      for (int i = 0; i < 3; i++) begin
         pulse_grow();
         do_move(RIGHT);
      end
      check("sat_len_s",   len_s, 8'd3);
      check("sat_full_s",  full_s, 1'b1);
      check("sat_body0_s", body_s[0], 8'hB8);
      check("sat_body3_s", body_s[3], 8'h88);
      check("sat_len_big", curr_length, 8'd5);
      check("sat_full_big", full, 1'b0);
      pulse_grow();
      do_move(RIGHT);
      check("sat2_len_s",   len_s, 8'd3);
      check("sat2_body0_s", body_s[0], 8'hC8);
      check("sat2_body3_s", body_s[3], 8'h98);

      // Restart in CALC with grow aborts the move and drops the grow.
      do_restart();
      dir_in    = RIGHT;
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      restart   = 1'b1;
      grow      = 1'b1;
      step();
      restart = 1'b0;
      grow    = 1'b0;
      check("abort_body0", body[0], 8'h88);
      check("abort_len",   curr_length, 8'd2);
      check("abort_done",  update_done, 1'b0);
      step();
      check("abort_done_e3", update_done, 1'b0);
      step();
      check("abort_body0_late", body[0], 8'h88);
      check("abort_done_late", update_done, 1'b0);
      do_move(RIGHT);
      check("abort_no_grow_len", curr_length, 8'd2);
      check("abort_next_body0", body[0], 8'h98);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
